// File: rtl/bram_result_reader_if.sv
// Output stream bundle of the result reader: valid/ready handshake with
// data and a last-beat marker.
interface bram_result_reader_if #(
    parameter int DWIDTH = 32
);
    logic              o_m_valid;
    logic              i_m_ready;
    logic [DWIDTH-1:0] o_m_data;
    logic              o_m_last;

    modport master (
        output o_m_valid,
        output o_m_data,
        output o_m_last,
        input  i_m_ready
    );

    modport slave (
        input  o_m_valid,
        input  o_m_data,
        input  o_m_last,
        output i_m_ready
    );
endinterface

// File: rtl/bram_result_reader.sv
// Streams num_cnt words from the result BRAM (addresses 0..num_cnt-1) out as
// a valid/ready stream; a 2-entry buffer hides the 1-cycle BRAM read latency.
module bram_result_reader #(
    parameter int CNT_BIT = 31,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_run,
    input  logic [CNT_BIT-1:0]  i_num_cnt,
    output logic                o_idle,
    output logic                o_read,
    output logic                o_done,
    output logic [AWIDTH-1:0]   addr,
    output logic                ce,
    output logic                we,
    output logic [DWIDTH-1:0]   d,
    input  logic [DWIDTH-1:0]   q,
    bram_result_reader_if.master m_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_BIT-1:0] num_cnt_reg;
    logic [CNT_BIT-1:0] rd_cnt_reg;
    logic [CNT_BIT-1:0] out_cnt_reg;
    logic               inflight_reg;
    logic               wr_ptr_reg, rd_ptr_reg;
    logic [1:0]         buf_cnt_reg;
    logic [DWIDTH-1:0]  head_data;

    logic               pop, push, issue, run_end;
    logic [2:0]         occupancy;

    assign pop       = m_if.o_m_valid & m_if.i_m_ready;
    assign push      = inflight_reg;
    assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg};

    // A pop in this cycle frees a slot, so a read may be issued even when
    // buffered plus in-flight words already total two.
    assign issue = o_read
                 && (rd_cnt_reg < num_cnt_reg)
                 && (occupancy < (pop ? 3'd3 : 3'd2));

    assign run_end = (state_reg == S_RUN)
                   && ((pop && m_if.o_m_last) || (num_cnt_reg == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_idle     = 1'b0;
        o_read     = 1'b0;
        o_done     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                o_idle = 1'b1;
                if (i_run) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_read = 1'b1;
                if (run_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cnt_reg <= '0;
        end else if ((state_reg == S_IDLE) && i_run) begin
            num_cnt_reg <= i_num_cnt;
        end else if (state_reg == S_DONE) begin
            num_cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else if (run_end) begin
            rd_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            if (issue) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_BIT'(1);
            end
            if (pop) begin
                out_cnt_reg <= out_cnt_reg + CNT_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            buf_cnt_reg  <= 2'd0;
        end else begin
            inflight_reg <= issue;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            buf_cnt_reg <= buf_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DWIDTH-1:0] entry_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= q;
                end
            end
        end
    endgenerate

    assign head_data = rd_ptr_reg ? g_buf[1].entry_reg : g_buf[0].entry_reg;

    assign m_if.o_m_valid = (buf_cnt_reg != 2'd0);
    assign m_if.o_m_data  = head_data;
    assign m_if.o_m_last  = m_if.o_m_valid && (out_cnt_reg == num_cnt_reg - CNT_BIT'(1));

    assign addr = rd_cnt_reg[AWIDTH-1:0];
    assign ce   = issue;
    assign we   = 1'b0;
    assign d    = '0;

endmodule

// File: tb/tb_bram_result_reader.sv
// Scoreboard bench for bram_result_reader: expected beats are queued at run
// start and matched against every accepted stream beat.
module tb_bram_result_reader;
    localparam int CNT_BIT = 31;
    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 12;
    localparam int DEPTH   = 1 << AWIDTH;

    logic               clk       = 1'b0;
    logic               reset_n   = 1'b0;
    logic               i_run     = 1'b0;
    logic [CNT_BIT-1:0] i_num_cnt = '0;
    logic               o_idle, o_read, o_done, ce, we;
    logic [AWIDTH-1:0]  addr;
    logic [DWIDTH-1:0]  d;
    logic [DWIDTH-1:0]  q = '0;

    bram_result_reader_if #(.DWIDTH(DWIDTH)) m_if ();

    bram_result_reader #(
        .CNT_BIT (CNT_BIT),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (i_run),
        .i_num_cnt (i_num_cnt),
        .o_idle    (o_idle),
        .o_read    (o_read),
        .o_done    (o_done),
        .addr      (addr),
        .ce        (ce),
        .we        (we),
        .d         (d),
        .q         (q),
        .m_if      (m_if)
    );

    always #5 clk = ~clk;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ce) q <= mem[addr];
    end

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
    } beat_t;

    beat_t sb_q[$];
    int checks   = 0;
    int errors   = 0;
    int beat_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitor: scoreboard pops, stall stability and issue throttling.
    int                occ       = 0;
    logic              hold_pend = 1'b0;
    logic [DWIDTH-1:0] hold_data = '0;
    logic              hold_last = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            occ       = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", m_if.o_m_valid, 1);
                check("stall_data", m_if.o_m_data, hold_data);
                check("stall_last", m_if.o_m_last, hold_last);
            end
            hold_pend = m_if.o_m_valid && !m_if.i_m_ready;
            hold_data = m_if.o_m_data;
            hold_last = m_if.o_m_last;
            if (ce) begin
                check("ce_occupancy", (occ < 2) || (m_if.o_m_valid && m_if.i_m_ready), 1);
            end
            if (m_if.o_m_valid && m_if.i_m_ready) begin
                beat_t exp_b;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_beat", m_if.o_m_data, 64'hDEAD);
                end else begin
                    exp_b = sb_q.pop_front();
                    check($sformatf("beat%0d_data", beat_cnt), m_if.o_m_data, exp_b.data);
                    check($sformatf("beat%0d_last", beat_cnt), m_if.o_m_last, exp_b.last);
                end
                beat_cnt++;
                occ = occ - 1;
            end
            if (ce) occ = occ + 1;
        end
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_idle"}, o_idle, 1);
        check({pfx, "_read"}, o_read, 0);
        check({pfx, "_done"}, o_done, 0);
        check({pfx, "_addr"}, addr, 0);
        check({pfx, "_ce"}, ce, 0);
        check({pfx, "_we"}, we, 0);
        check({pfx, "_d"}, d, 0);
        check({pfx, "_valid"}, m_if.o_m_valid, 0);
        check({pfx, "_data"}, m_if.o_m_data, 0);
        check({pfx, "_last"}, m_if.o_m_last, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle 1.
    task automatic start(input int n);
        beat_t b;
        i_run     = 1'b1;
        i_num_cnt = CNT_BIT'(n);
        for (int i = 0; i < n; i++) begin
            b.data = mem[i % DEPTH];
            b.last = (i == n - 1);
            sb_q.push_back(b);
        end
        @(posedge clk);
        #1;
        i_run = 1'b0;
    endtask

    // Full-throughput run with a cycle-exact timeline check.
    task automatic run_free(input int n, input bit retrig);
        int done_cyc;
        done_cyc = (n == 0) ? 2 : n + 3;
        start(n);
        for (int k = 1; k <= done_cyc + 2; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (retrig) begin
                if (k == 2) begin
                    i_run     = 1'b1;
                    i_num_cnt = CNT_BIT'(99);
                end else begin
                    i_run = 1'b0;
                end
            end
            check($sformatf("n%0d_c%0d_read", n, k), o_read, k < done_cyc);
            check($sformatf("n%0d_c%0d_done", n, k), o_done, k == done_cyc);
            check($sformatf("n%0d_c%0d_idle", n, k), o_idle, k > done_cyc);
            check($sformatf("n%0d_c%0d_valid", n, k), m_if.o_m_valid, (k >= 3) && (k <= n + 2));
            check($sformatf("n%0d_c%0d_last", n, k), m_if.o_m_last, (n > 0) && (k == n + 2));
            check($sformatf("n%0d_c%0d_ce", n, k), ce, k <= n);
            if (k <= n) check($sformatf("n%0d_c%0d_addr", n, k), addr, k - 1);
        end
        check($sformatf("n%0d_sb_left", n), sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dones;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
        m_if.i_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_free(4, 1'b0);
        $display("free-running N=4 done, checks=%0d", checks);
        run_free(1, 1'b0);
        $display("single word N=1 done, checks=%0d", checks);
        run_free(0, 1'b0);
        $display("zero count N=0 done, checks=%0d", checks);

        // Backpressure: random ready, all 16 words in order, one done pulse.
        base  = beat_cnt;
        dones = 0;
        start(16);
        for (int k = 0; k < 600; k++) begin
            if (o_done) begin
                dones++;
                break;
            end
            m_if.i_m_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("bp_done_seen", dones, 1);
        m_if.i_m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", o_idle, 1);
        check("bp_done_single", o_done, 0);
        check("bp_beats", beat_cnt - base, 16);
        check("bp_sb_left", sb_q.size(), 0);
        $display("backpressure N=16 done, checks=%0d", checks);

        // Reset in the middle of a run, then a fresh short run.
        base = beat_cnt;
        start(8);
        for (int k = 0; k < 50; k++) begin
            if (beat_cnt - base >= 3) break;
            @(posedge clk);
            #1;
        end
        check("rst_three_beats", beat_cnt - base >= 3, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrun_rst");
        @(posedge clk);
        #1;
        sb_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_free(2, 1'b0);
        $display("reset mid-run then N=2 done, checks=%0d", checks);

        run_free(5, 1'b1);
        $display("re-trigger ignored N=5 done, checks=%0d", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_result_reader.md
# bram_result_reader

Reads `i_num_cnt` consecutive 32-bit result words from the result BRAM, starting at address 0, and emits them as a valid/ready output stream with a last-beat flag. It is the read-out end of the result memory that the multiply data mover fills, and it runs after that mover reports done. A 2-entry output buffer absorbs the 1-cycle BRAM read latency, so the block sustains one beat per cycle under any backpressure pattern without losing or duplicating words.

## Interface
- `CNT_BIT`, default 31: width of the count and address counters.
- `DWIDTH`, default 32: BRAM and stream data width.
- `AWIDTH`, default 12: BRAM address width. Counter addresses are truncated to AWIDTH bits.
- `clk`  in  1  the single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  start pulse; sampled only in S_IDLE.
- `i_num_cnt`  in  CNT_BIT  number of words to read, captured when `i_run` is accepted.
- `o_idle`  out  1  high while the FSM is in S_IDLE.
- `o_read`  out  1  high while the FSM is in S_RUN.
- `o_done`  out  1  high for exactly one cycle while the FSM is in S_DONE.
- `addr`  out  AWIDTH  BRAM read address.
- `ce`  out  1  BRAM chip enable; equals read-issue.
- `we`  out  1  BRAM write enable; constant 0.
- `d`  out  DWIDTH  BRAM write data; constant 0.
- `q`  in  DWIDTH  BRAM read data; valid 1 cycle after `ce`.
- `o_m_valid`  out  1  stream data valid.
- `i_m_ready`  in  1  stream sink ready.
- `o_m_data`  out  DWIDTH  stream data; the head of the output buffer.
- `o_m_last`  out  1  marks the beat with index num_cnt-1.

## Operation
- **FSM states:** S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
  - S_IDLE -> S_RUN on `i_run`.
  - S_RUN -> S_DONE when the last beat is accepted (`o_m_valid & i_m_ready & o_m_last`), or when the captured count is 0.
  - S_DONE -> S_IDLE unconditionally.
- **Count capture:** `num_cnt` is loaded from `i_num_cnt` when `i_run` is high in S_IDLE. It is cleared in S_DONE. `i_run` outside S_IDLE is ignored and does not change `num_cnt`.
- **Read counter `rd_cnt`:** counts issued reads, 0..num_cnt.
  - Issue condition: `o_read & (rd_cnt < num_cnt) & (buf_cnt + inflight - pop < 2)`, where `pop = o_m_valid & i_m_ready`.
  - `addr = rd_cnt[AWIDTH-1:0]`. `ce` equals the issue condition.
- **In-flight flag:** `inflight` is a 1-bit register equal to the previous cycle's `ce`. When `inflight` is high, `q` is pushed into the buffer at that cycle's edge.
- **Output buffer:** 2-entry FIFO, registered output.
  - The issue condition guarantees the buffer never overflows, including when a push and a pop occur in the same cycle.
  - `o_m_valid = (buf_cnt != 0)`.
- **Beat counter `out_cnt`:** increments on each pop. `o_m_last = o_m_valid & (out_cnt == num_cnt-1)`.
- **Counter clearing:** `rd_cnt` and `out_cnt` clear to 0 on the S_RUN -> S_DONE transition.
- **Address wrap:** if num_cnt > 2^AWIDTH, `addr` wraps modulo 2^AWIDTH. No error is flagged.
- **Reset:** an asynchronous `reset_n` low at any time, including mid-RUN, clears:
  - FSM, counters, buffer and `inflight`;
  - any pending in-flight read is discarded.
- **Reset values:**
  - `o_idle` = 1.
  - All other outputs = 0: `o_read`, `o_done`, `addr`, `ce`, `we`, `d`, `o_m_valid`, `o_m_data`, `o_m_last`.

## Timing
- `i_run` sampled at edge E0 -> `o_read` = 1 and first `ce` (addr 0) in cycle 1.
- `q` for addr 0 is valid in cycle 2 and pushed at the end of cycle 2. `o_m_valid` first rises in cycle 3, giving a 2-cycle latency from `ce` to `o_m_valid`.
- With `i_m_ready` held high, N>=1 beats appear in cycles 3..N+2, one per cycle.
  - `o_m_last` is high in cycle N+2.
  - `o_done` is high in cycle N+3.
  - `o_idle` is high from cycle N+4.
- With num_cnt = 0: S_RUN for cycle 1 only, no `ce`, no beats, `o_done` in cycle 2.
- **Stream rules:**
  - While `o_m_valid` = 1 and `i_m_ready` = 0, `o_m_data` and `o_m_last` hold stable.
  - `o_m_valid` never drops without a pop.
- **Stall recovery:** when `i_m_ready` deasserts, reads stop once `buf_cnt + inflight` reaches 2. Reads resume in the same cycle in which a pop occurs.

## Test plan
- **Free-running stream:** BRAM preloaded mem[i] = 32'hA000_0000+i; `i_run` with N=4, `i_m_ready` = 1 -> beats A0000000..A0000003 in consecutive cycles 3..6, `o_m_last` only on the 4th beat, `o_done` 1 cycle in cycle 7, `o_idle` from cycle 8.
- **Backpressure:** N=16, `i_m_ready` toggling 1,0,0,1,... pseudo-randomly -> all 16 words delivered in order, no duplicates or drops, data stable during stalls, `ce` never issued while `buf_cnt + inflight` = 2 with no pop.
- **Single word:** N=1 -> exactly one `ce` at addr 0, one beat with `o_m_last` = 1, `o_done` in cycle 4.
- **Zero count:** N=0 -> no `ce`, no `o_m_valid`, `o_done` in cycle 2, back to S_IDLE.
- **Reset mid-run:** N=8, `reset_n` pulsed low after the 3rd beat -> all outputs at reset values immediately. A subsequent `i_run` with N=2 reads from addr 0 and streams mem[0], mem[1] only.
- **Re-trigger ignored:** `i_run` re-pulsed with N=99 during S_RUN of an N=5 transfer -> still exactly 5 beats, `o_m_last` on beat 5, a single `o_done`.
